servo_pwm_drv: RTL
==================

Name: servo_pwm_drv

Overview:
- Downstream stage of the PID controller. Consumes the signed controller output Yk and converts it to a PWM magnitude plus a direction bit for the servo H-bridge.
- The PWM carrier is free-running. Duty and direction take effect only at period boundaries, and a dead-time is inserted whenever the direction reverses.
- Also generates the periodic sample strobe that drives the controller's Rx_En, so sampling stays locked to the PWM carrier.

Parameters:
- cant_bits, 16: controller data width. Yk is 2*cant_bits wide.
- PER, 1000: PWM period in clock cycles. PER >= 2.
- SHIFT, 6: arithmetic right shift applied to |Yk| to form the duty count.
- DEAD, 20: dead-time in clock cycles on direction reversal. 1 <= DEAD < PER.
- DIV_SAMP, 10: number of PWM periods per Samp_Tick.

Ports:
- Clk_G  in  1  system clock.
- Rst_G  in  1  reset, asynchronous, active-low.
- En  in  1  drive enable. Low forces the output off.
- Yk  in  2*cant_bits  signed controller output.
- Ld_Yk  in  1  one-cycle strobe: Yk is valid.
- Pwm  out  1  registered PWM to the bridge.
- Dir  out  1  registered direction. 1 = Yk negative.
- Samp_Tick  out  1  one-cycle pulse to the controller's Rx_En.
- Sat  out  1  last loaded sample was clipped.

Behaviour:
- Reset (Rst_G low, asynchronous):
  - Outputs: Pwm=0, Dir=0, Samp_Tick=0, Sat=0.
  - Internal state: Cnt=0, period divider=0, shadow and active duty=0, shadow and active dir=0, FSM=S_IDLE.
  - Reset mid-period aborts the period with no glitch beyond the asynchronous clear.
- Carrier:
  - Cnt counts 0..PER-1 and wraps. Width is clog2(PER).
  - "Period end" means Cnt==PER-1.
  - Cnt runs regardless of En and FSM state.
- Load path (Ld_Yk=1): the shadow registers update on the next edge (latency 1).
  - Sign: dir_sh = Yk[MSB].
  - Magnitude: mag = |Yk|. The most-negative value maps to 2^(2*cant_bits-1)-1.
  - Duty: d = mag >>> SHIFT. duty_sh = min(d, PER). Sat = (d > PER).
  - No Ld_Yk: the shadow registers hold their value.
- Transfer at period end:
  - active duty <= duty_sh; active dir <= dir_sh.
  - If Ld_Yk coincides with period end, the transfer takes the pre-load shadow value. The new sample applies one period later.
- FSM, evaluated at period end unless noted:
  - S_IDLE: Pwm=0. Go to S_RUN at the first period end after Ld_Yk has been seen with En=1.
  - S_RUN: Pwm <= (Cnt < duty_act), registered, so 1 cycle behind Cnt. duty_act=PER gives constant high; 0 gives constant low. At period end, if dir_sh != Dir and duty_sh != 0, go to S_DEAD.
  - S_DEAD: entered on the period-end edge. On that same edge Dir <= dir_sh. Pwm=0 for DEAD cycles (Cnt 0..DEAD-1), then return to S_RUN. Cnt is not reset, so active time in that period = max(duty_act - DEAD, 0).
  - A direction change with duty_sh=0 updates Dir without entering dead-time.
- En:
  - En=0 in any state: FSM to S_IDLE and Pwm=0 on the next edge. Dir holds. The shadow registers still load.
  - Re-enable waits for period end and a fresh Ld_Yk.
- Samp_Tick:
  - Period divider counts period ends 0..DIV_SAMP-1.
  - Samp_Tick=1 for exactly one cycle on the clock after the period end where the divider wraps.
  - First tick comes DIV_SAMP*PER cycles after reset release.
- Sat is updated only on loads and is sticky until the next load.

Decomposition:
- Shared package holds:
  - width function clog2.
  - FSM state encodings S_IDLE/S_RUN/S_DEAD (2-bit).
  - cant_bits default.
- Natural sub-module: servo_sat_scale, the combinational abs/shift/clamp plus Sat.
- Counters and FSM stay in the top.

Test Plan:
- Reset release, then Ld_Yk with Yk=32000 → duty 500, Dir=0, Sat=0. From the next period on, Pwm is high exactly 500 of every 1000 cycles.
- From the above, load Yk=-6400 → at period end Dir=1. Pwm low for cycles 0..19, then high for 80 cycles. Following periods: 100 high cycles, no dead-time.
- Yk=10_000_000 → Pwm constantly high, Sat=1. Then Yk=-2^31 → Dir flips, Sat=1, 20-cycle dead-time, then 980 high cycles.
- Ld_Yk asserted exactly at Cnt=999 with a new duty → that period boundary uses the old duty; the new duty appears in the following period.
- Free run 30000 cycles → Samp_Tick pulses at cycles 10000, 20000, 30000 (±1 registered offset), each 1 cycle wide. No Samp_Tick is missed across En toggles.
- Rst_G pulled low at Cnt=437 while Pwm=1 → Pwm=0 and Dir=0 immediately. After release, FSM is in S_IDLE and Pwm stays 0 until a Ld_Yk followed by a period end.

Source files
------------

// File: rtl/servo_pwm_drv_pkg.sv
// servo_pwm_drv_pkg: shared width helper, FSM encodings and defaults for the servo PWM driver
package servo_pwm_drv_pkg;
    localparam int CANT_BITS = 16;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/servo_pwm_drv_if.sv
// servo_pwm_drv_if: controller-side command inputs and bridge-side outputs of the servo PWM driver
interface servo_pwm_drv_if
    import servo_pwm_drv_pkg::*;
#(
    parameter int cant_bits = CANT_BITS
);
    logic                          En;
    logic signed [2*cant_bits-1:0] Yk;
    logic                          Ld_Yk;
    logic                          Pwm;
    logic                          Dir;
    logic                          Samp_Tick;
    logic                          Sat;
    modport master (output En, Yk, Ld_Yk, input Pwm, Dir, Samp_Tick, Sat);
    modport slave (input En, Yk, Ld_Yk, output Pwm, Dir, Samp_Tick, Sat);
endinterface

// File: rtl/servo_sat_scale.sv
// servo_sat_scale: |Yk| >> SHIFT clamped to PER, with saturation flag
module servo_sat_scale
    import servo_pwm_drv_pkg::*;
#(
    parameter int cant_bits = CANT_BITS,
    parameter int PER = 1000,
    parameter int SHIFT = 6,
    localparam int W = 2*cant_bits,
    localparam int DW = clog2(PER+1)
) (
    input  logic signed [W-1:0] Yk,
    output logic [DW-1:0]       duty,
    output logic                sat
);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    logic [W-1:0] mag;
    logic [W-1:0] d;
    // the most-negative input has no positive twin, so it folds onto the largest positive value
    assign mag = !Yk[W-1] ? $unsigned(Yk) : ($unsigned(Yk) == MOST_NEG) ? MAX_POS : $unsigned(-Yk);
    assign d = mag >> SHIFT;
    assign sat = d > W'(PER);
    assign duty = sat ? DW'(PER) : d[DW-1:0];
endmodule

// File: rtl/servo_pwm_drv.sv
// servo_pwm_drv: PWM magnitude/direction driver with boundary-aligned updates, reversal dead-time and sample strobe
module servo_pwm_drv
    import servo_pwm_drv_pkg::*;
#(
    parameter int cant_bits = CANT_BITS,
    parameter int PER = 1000,
    parameter int SHIFT = 6,
    parameter int DEAD = 20,
    parameter int DIV_SAMP = 10,
    localparam int CW = clog2(PER),
    localparam int DW = clog2(PER+1),
    localparam int VW = clog2(DIV_SAMP)
) (
    input logic            Clk_G,
    input logic            Rst_G,
    servo_pwm_drv_if.slave bus
);
    logic [CW-1:0] cnt;
    logic [VW-1:0] div;
    logic [DW-1:0] duty_n;
    logic [DW-1:0] duty_sh;
    logic [DW-1:0] duty_act;
    logic          sat_n;
    logic          dir_sh;
    logic          armed;
    logic          pe;
    state_t        state;
    servo_sat_scale #(.cant_bits(cant_bits), .PER(PER), .SHIFT(SHIFT)) u_scale (
        .Yk(bus.Yk),
        .duty(duty_n),
        .sat(sat_n)
    );
    assign pe = cnt == CW'(PER-1);
    always_ff @(posedge Clk_G or negedge Rst_G)
        if (!Rst_G) begin
            cnt <= '0;
            div <= '0;
            bus.Samp_Tick <= 1'b0;
        end else begin
            cnt <= pe ? '0 : cnt + CW'(1);
            bus.Samp_Tick <= pe && div == VW'(DIV_SAMP-1);
            if (pe) div <= (div == VW'(DIV_SAMP-1)) ? '0 : div + VW'(1);
        end
    always_ff @(posedge Clk_G or negedge Rst_G)
        if (!Rst_G) begin
            duty_sh <= '0;
            dir_sh <= 1'b0;
            bus.Sat <= 1'b0;
        end else if (bus.Ld_Yk) begin
            duty_sh <= duty_n;
            dir_sh <= bus.Yk[2*cant_bits-1];
            bus.Sat <= sat_n;
        end
    // armed remembers a sample taken while enabled; dropping En forgets it
    always_ff @(posedge Clk_G or negedge Rst_G)
        if (!Rst_G) begin
            state <= S_IDLE;
            duty_act <= '0;
            armed <= 1'b0;
            bus.Pwm <= 1'b0;
            bus.Dir <= 1'b0;
        end else begin
            if (pe) duty_act <= duty_sh;
            armed <= bus.En && (armed || bus.Ld_Yk);
            if (!bus.En) begin
                state <= S_IDLE;
                bus.Pwm <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        bus.Pwm <= 1'b0;
                        if (pe && armed) begin
                            state <= S_RUN;
                            bus.Dir <= dir_sh;
                        end
                    end
                    S_RUN: begin
                        bus.Pwm <= DW'(cnt) < duty_act;
                        if (pe) begin
                            bus.Dir <= dir_sh;
                            if (dir_sh != bus.Dir && duty_sh != '0) state <= S_DEAD;
                        end
                    end
                    S_DEAD: begin
                        bus.Pwm <= 1'b0;
                        if (cnt == CW'(DEAD-1)) state <= S_RUN;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
endmodule
